alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
Upstream issue stage for the struct/union ALU datapath. It buffers instr_t instruction words from a producer in a DEPTH-entry FIFO using a valid/ready handshake. It presents the oldest word on IW to the combinational ALU and pops it when the downstream result-capture stage accepts. It also screens words: illegal encodings are dropped and counted, and divide-by-zero is flagged so the downstream stage can suppress the result.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 8, width of err_cnt; saturating

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all queued entries; err_cnt kept
in_valid  in  1  producer has an instruction
in_ready  out  1  queue can accept this cycle
in_instr  in  instr_t (128: opc 32, op_type 32, op_a 32, op_b 32)  incoming instruction word
IW  out  instr_t  head instruction driven to ALU
iw_valid  out  1  IW holds a valid instruction
iw_ready  in  1  downstream captures ALU result this cycle
iw_dz  out  1  head is div with op_b.u_data==0
count  out  $clog2(DEPTH)+1  entries held
err_cnt  out  CNT_W  dropped illegal words, saturating

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, err_cnt=0. in_ready=1 on the following cycle. IW=0, iw_valid=0, iw_dz=0.
- Push: in_valid && in_ready at an edge.
  - If opc>5 or op_type>1, the word is illegal: not stored, err_cnt+1 (holds at 2^CNT_W-1). in_ready is not affected.
  - Otherwise the word is written at wr_ptr and wr_ptr increments mod DEPTH.
- Pop: iw_valid && iw_ready at an edge. rd_ptr increments mod DEPTH.
- in_ready = (count<DEPTH). It is combinational from the registered count. No write-through when full, even if a pop occurs in the same cycle.
- iw_valid = (count!=0).
- IW = mem[rd_ptr] when iw_valid, else all zeros. It is show-ahead: the head is visible without a request.
- Latency: a word pushed at edge N is on IW with iw_valid=1 after edge N if the queue was empty (first-word latency 1 cycle). It is popped no earlier than edge N+1.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop with count==0: no pop (iw_valid=0); the push occurs.
- Illegal push at the same edge as a pop: count decrements.
- iw_dz = iw_valid && IW.opc==div && IW.op_b.u_data==0. It applies to both op_types. The word is still issued; handling it is a downstream decision.
- IW and iw_valid are stable while iw_valid && !iw_ready. The head is never replaced until popped.
- flush=1: at the edge, pointers and count go to 0. Any same-cycle push and pop are ignored, and a same-cycle illegal push is not counted.
- Priority: rst > flush > push/pop.
- Reset mid-operation discards all entries. No partial state survives.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally at DEPTH-1 -> 0. Order is strictly FIFO across the wrap.
- Memory contents are not reset; only pointers and count are. IW zero-masking hides stale data.

Test Plan:
1. After reset, push {add,sign,5,-3} with iw_ready=0 -> next cycle iw_valid=1, IW.op_a=5, IW.op_b=0xFFFFFFFD, count=1, iw_dz=0.
2. Push 4 words with iw_ready=0 (DEPTH=4) -> in_ready=0 once count=4. A 5th in_valid is not accepted. Then iw_ready=1 for 4 cycles -> words pop in push order, count 4,3,2,1,0, then iw_valid=0.
3. Continuous push+pop for 10 words starting from count=2 -> count stays 2, pointers wrap twice, output order matches input order exactly.
4. Push {div,unsign,100,0} -> iw_dz=1 while it is head. Push {div,sign,100,7} next -> iw_dz=0 once it becomes head.
5. Push opc=7, then op_type=2, then a valid sub -> err_cnt=2, count=1, IW.opc=sub. With CNT_W=2, 5 illegal words -> err_cnt holds at 3.
6. Fill 3 entries, assert flush with in_valid=1 and iw_ready=1 at the same edge -> count=0, iw_valid=0, err_cnt unchanged. Assert rst with 2 entries queued -> count=0, err_cnt=0, in_ready=1 on the following cycle.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational ALU: show-ahead FIFO of instr_t words
// that drops illegal encodings (saturating count) and flags divide-by-zero at the head.
package alu_issue_pkg;
    typedef union packed {
        logic [31:0]        u_data;
        logic signed [31:0] s_data;
    } data_u;

    typedef struct packed {
        logic [31:0] opc;
        logic [31:0] op_type;
        data_u       op_a;
        data_u       op_b;
    } instr_t;

    // opc: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or; op_type: 0 unsigned, 1 signed
    localparam logic [31:0] OPC_DIV   = 32'd3;
    localparam logic [31:0] OPC_LAST  = 32'd5;
    localparam logic [31:0] TYPE_LAST = 32'd1;
endpackage

module alu_issue_queue
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  instr_t                  in_instr,
    output instr_t                  IW,
    output logic                    iw_valid,
    input  logic                    iw_ready,
    output logic                    iw_dz,
    output logic [$clog2(DEPTH):0]  count,
    output logic [CNT_W-1:0]        err_cnt
);
    localparam int AW = $clog2(DEPTH);

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]     count_reg, count_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic legal;
    logic wr_en;
    logic err_en;
    logic pop_en;

    assign in_ready = (count_reg < (AW+1)'(DEPTH));
    assign iw_valid = (count_reg != '0);
    assign count    = count_reg;
    assign err_cnt  = err_cnt_reg;

    always_comb begin
        legal  = (in_instr.opc <= OPC_LAST) && (in_instr.op_type <= TYPE_LAST);
        // flush swallows everything presented in its cycle, including the error tally
        wr_en  = in_valid && in_ready && legal && !flush;
        err_en = in_valid && in_ready && !legal && !flush;
        pop_en = iw_valid && iw_ready && !flush;
    end

    always_comb begin
        IW    = iw_valid ? mem[rd_ptr_reg] : '0;
        iw_dz = iw_valid && (IW.opc == OPC_DIV) && (IW.op_b.u_data == 32'd0);
    end

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        err_cnt_next = err_cnt_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_en)
                wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_en)
                rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + (AW+1)'(wr_en) - (AW+1)'(pop_en);
            if (err_en && (err_cnt_reg != '1))
                err_cnt_next = err_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Storage is never cleared; the IW mask hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem[wr_ptr_reg] <= in_instr;
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed plan sequences followed by random traffic,
// checked against a queue-based reference model.
module tb_alu_issue_queue;
    import alu_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, iw_valid, iw_ready, iw_dz;
    instr_t in_instr, IW;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0] err_cnt;

    alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .IW(IW), .iw_valid(iw_valid), .iw_ready(iw_ready), .iw_dz(iw_dz),
        .count(count), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    instr_t exp_q[$];
    int model_err = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int unsigned opc, input int unsigned typ,
                                  input int unsigned a, input int unsigned b);
        instr_t w;
        w.opc = opc;
        w.op_type = typ;
        w.op_a.u_data = a;
        w.op_b.u_data = b;
        return w;
    endfunction

    function automatic bit is_legal(input instr_t w);
        return (w.opc < 6) && (w.op_type < 2);
    endfunction

    function automatic instr_t rand_word();
        int unsigned opc, typ, b;
        opc = ($urandom % 8 == 0) ? $urandom_range(6, 300) : $urandom_range(0, 5);
        typ = ($urandom % 8 == 0) ? $urandom_range(2, 9) : $urandom_range(0, 1);
        b   = ($urandom % 4 == 0) ? 0 : $urandom;
        return mk(opc, typ, $urandom, b);
    endfunction

    // Check the state left by the previous edge, then drive one cycle of stimulus.
    task automatic step(input logic v, input instr_t w, input logic rdy,
                        input logic fl, input logic rs);
        int n;
        bit dz;
        n = exp_q.size();
        chk("count", 128'(count), 128'(n));
        chk("in_ready", 128'(in_ready), 128'(n < DEPTH));
        chk("iw_valid", 128'(iw_valid), 128'(n != 0));
        chk("err_cnt", 128'(err_cnt), 128'(model_err));
        dz = (n != 0) && (exp_q[0].opc == 3) && (exp_q[0].op_b.u_data == 0);
        chk("iw_dz", 128'(iw_dz), 128'(dz));
        if (n != 0) chk("head", IW, exp_q[0]);
        else        chk("iw_zero", IW, 128'(0));

        in_valid = v;
        in_instr = w;
        iw_ready = rdy;
        flush    = fl;
        rst      = rs;
        if (rs) begin
            exp_q.delete();
            model_err = 0;
        end else if (fl) begin
            exp_q.delete();
        end else if (v && n < DEPTH) begin
            if (is_legal(w)) exp_q.push_back(w);
            else if (model_err < ERR_MAX) model_err++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (started && !rst && !flush && iw_valid && iw_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 128'(1), 128'(0));
            end else begin
                instr_t e;
                e = exp_q.pop_front();
                n_pop++;
                chk("pop_word", IW, e);
                $display("pop %0d: opc=%0d type=%0d a=%h b=%h", n_pop, e.opc, e.op_type,
                         e.op_a.u_data, e.op_b.u_data);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; iw_ready = 1'b0; in_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        // 1: single push shows up one cycle later
        step(1'b1, mk(0, 1, 5, 32'hFFFF_FFFD), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t1_op_a", 128'(IW.op_a.u_data), 128'(5));
        chk("t1_op_b", 128'(IW.op_b.u_data), 128'(32'hFFFF_FFFD));

        // 2: fill to DEPTH, extra pushes refused, then drain in order
        for (int i = 0; i < 3; i++) step(1'b1, mk(i + 1, 0, 32'h100 + i, 32'h200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(4, 0, 32'hDEAD, 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(5, 1, 32'hBEEF, 2), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // 3: steady push+pop at count 2 across two pointer wraps
        step(1'b1, mk(0, 0, 32'h10, 32'h20), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1, 0, 32'h11, 32'h21), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, mk(i % 6, i % 2, 32'h1000 + i, 32'h77 + i), 1'b1, 1'b0, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b0);

        // 4: divide-by-zero flag follows the head
        step(1'b1, mk(3, 0, 100, 0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(3, 1, 100, 7), 1'b0, 1'b0, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b0);

        // 5: illegal words dropped and counted, counter saturates
        step(1'b1, mk(7, 0, 1, 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 2, 1, 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1, 1, 9, 4), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("t5_err2", 128'(err_cnt), 128'(2));
        for (int i = 0; i < 5; i++) step(1'b1, mk(6 + i, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        chk("t5_sat", 128'(err_cnt), 128'(ERR_MAX));

        // 6: flush with concurrent push/pop, then reset with entries queued
        for (int i = 0; i < 3; i++) step(1'b1, mk(2, 1, i, i), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(9, 0, 0, 0), 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        step(1'b1, mk(0, 0, 1, 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 0, 2, 2), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(0, 0, 3, 3), 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, rand_word(), ($urandom % 3) != 0,
                 ($urandom % 50) == 0, ($urandom % 150) == 0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
